// File: rtl/dca_matrix_store_sequencer.sv
// Matrix store sequencer for the DCA matrix LSU.
// Walks a strided matrix row by row, splits every row into AXI INCR write
// bursts (at most 16 beats, never crossing a 4KB page), issues the AW
// requests, emits one transaction-info word per data beat to the merge stage
// and counts B responses until the whole store has been acknowledged.
module dca_matrix_store_sequencer #(
  parameter int BW_ADDR      = 32,
  parameter int BW_DATA      = 128,
  parameter int BW_ELEM      = 32,
  parameter int BW_DIM       = 8,
  parameter int MAX_OUTSTAND = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  input  logic [BW_ADDR-1:0]         inst_addr,
  input  logic [BW_ADDR-1:0]         inst_stride,
  input  logic [BW_DIM-1:0]          inst_num_row_m1,
  input  logic [BW_DIM-1:0]          inst_num_col_m1,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [BW_ADDR-1:0]         awaddr,
  output logic [7:0]                 awlen,
  output logic                       txn_valid,
  input  logic                       txn_ready,
  output logic [$clog2(BW_DATA)-1:0] txn_bitaddr,
  output logic                       txn_last_burst,
  output logic                       txn_last_matrix,
  input  logic                       bvalid,
  output logic                       busy,
  output logic                       done
);

  localparam int BEAT_BYTES = BW_DATA / 8;
  localparam int BB_SH      = $clog2(BEAT_BYTES);
  localparam int OFF_W      = BB_SH;
  localparam int BIT_W      = $clog2(BW_DATA);
  localparam int ELEM_SH    = $clog2(BW_ELEM / 8);
  localparam int CNT_W      = 16;
  localparam int OUT_W      = $clog2(MAX_OUTSTAND + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ADDR  = 3'd2,
    BEAT  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state, state_nxt;

  logic [BW_ADDR-1:0]   stride_q;
  logic [BW_DIM-1:0]    num_row_q;
  logic [BW_DIM-1:0]    num_col_q;
  logic [BW_ADDR-1:0]   row_addr;
  logic [BW_DIM-1:0]    row_cnt;
  logic [OFF_W-1:0]     off_q;
  logic [CNT_W-1:0]     row_beats_left;
  logic [7:0]           beat_cnt;
  logic                 first_beat;
  logic [OUT_W-1:0]     outstanding;
  logic [BW_ADDR-1:0]   awaddr_q;
  logic [7:0]           awlen_q;

  logic [OFF_W-1:0]     off_c;
  logic [CNT_W-1:0]     rb_c;
  logic [CNT_W-1:0]     nb_c;
  logic [BW_ADDR-1:0]   row_base_c;
  logic [CNT_W-1:0]     burst_beats_c;
  logic [CNT_W-1:0]     rem_c;
  logic [BW_ADDR-1:0]   next_burst_addr_c;
  logic                 last_beat_c;
  logic                 last_row_c;
  logic                 aw_hs;
  logic                 b_dec;

  // Clamp a burst to the remaining row beats, the AXI 16-beat INCR limit
  // and the beats left before the next 4KB page boundary.
  function automatic logic [CNT_W-1:0] calc_len(input logic [11:0] a_lo,
                                                input logic [CNT_W-1:0] left);
    logic [CNT_W-1:0] to4k;
    logic [CNT_W-1:0] len;
    to4k = (CNT_W'(4096) - CNT_W'(a_lo)) >> BB_SH;
    len  = left;
    if (len > CNT_W'(16)) len = CNT_W'(16);
    if (len > to4k)       len = to4k;
    return len;
  endfunction

  assign off_c             = row_addr[OFF_W-1:0];
  assign rb_c              = (CNT_W'(num_col_q) + CNT_W'(1)) << ELEM_SH;
  assign nb_c              = (CNT_W'(off_c) + rb_c + CNT_W'(BEAT_BYTES - 1)) >> BB_SH;
  assign row_base_c        = {row_addr[BW_ADDR-1:OFF_W], {OFF_W{1'b0}}};
  assign burst_beats_c     = CNT_W'(awlen_q) + CNT_W'(1);
  assign rem_c             = row_beats_left - burst_beats_c;
  assign next_burst_addr_c = awaddr_q + (BW_ADDR'(burst_beats_c) << BB_SH);
  assign last_beat_c       = (beat_cnt == awlen_q);
  assign last_row_c        = (row_cnt == num_row_q);

  assign inst_ready      = (state == IDLE);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign awvalid         = (state == ADDR) && (outstanding < OUT_W'(MAX_OUTSTAND));
  assign awaddr          = awaddr_q;
  assign awlen           = awlen_q;
  assign txn_valid       = (state == BEAT);
  assign txn_bitaddr     = (state == BEAT && first_beat) ? BIT_W'({off_q, 3'b000}) : '0;
  assign txn_last_burst  = (state == BEAT) && last_beat_c;
  assign txn_last_matrix = (state == BEAT) && last_beat_c && (rem_c == '0) && last_row_c;

  assign aw_hs = awvalid && awready;
  assign b_dec = bvalid && (outstanding != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (inst_valid) state_nxt = CALC;
      CALC:  state_nxt = ADDR;
      ADDR:  if (aw_hs) state_nxt = BEAT;
      BEAT: begin
        if (txn_ready && last_beat_c) begin
          if (rem_c != '0)      state_nxt = ADDR;
          else if (!last_row_c) state_nxt = CALC;
          else                  state_nxt = DRAIN;
        end
      end
      DRAIN: if (outstanding == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row walk, burst split and beat counting
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q       <= '0;
      num_row_q      <= '0;
      num_col_q      <= '0;
      row_addr       <= '0;
      row_cnt        <= '0;
      off_q          <= '0;
      row_beats_left <= '0;
      beat_cnt       <= '0;
      first_beat     <= 1'b0;
      awaddr_q       <= '0;
      awlen_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_valid) begin
            row_addr  <= inst_addr;
            stride_q  <= inst_stride;
            num_row_q <= inst_num_row_m1;
            num_col_q <= inst_num_col_m1;
            row_cnt   <= '0;
          end
        end
        CALC: begin
          off_q          <= off_c;
          row_beats_left <= nb_c;
          awaddr_q       <= row_base_c;
          awlen_q        <= 8'(calc_len(row_base_c[11:0], nb_c) - CNT_W'(1));
          first_beat     <= 1'b1;
          beat_cnt       <= '0;
        end
        ADDR: beat_cnt <= '0;
        BEAT: begin
          if (txn_ready) begin
            first_beat <= 1'b0;
            if (!last_beat_c) begin
              beat_cnt <= beat_cnt + 8'd1;
            end else if (rem_c != '0) begin
              // Continue the same row with the next burst
              awaddr_q       <= next_burst_addr_c;
              awlen_q        <= 8'(calc_len(next_burst_addr_c[11:0], rem_c) - CNT_W'(1));
              row_beats_left <= rem_c;
              beat_cnt       <= '0;
            end else if (!last_row_c) begin
              // Row start addresses accumulate the stride, no multiplier
              row_addr <= row_addr + stride_q;
              row_cnt  <= row_cnt + BW_DIM'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bursts awaiting a B response; bready is always high
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_dec})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
